// File: rtl/scs8hd_rrarb4_1.sv
// Four-requester round-robin arbiter with a bounded hold time for a shared cell-level cone.
// Grants are registered one-hot. A one-cycle bubble always separates two owners.
module scs8hd_rrarb4_1 #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
`ifdef SC_USE_PG_PIN
  input  logic                     vpwr,
  input  logic                     vgnd,
  input  logic                     vpb,
  input  logic                     vnb,
`endif
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     EN,
  input  logic [NREQ-1:0]          REQ,
  output logic [NREQ-1:0]          GNT,
  output logic [$clog2(NREQ)-1:0]  GNT_ID,
  output logic                     GNT_VLD,
  output logic                     TOUT
);

  localparam int PTR_W = $clog2(NREQ);
  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

`ifndef SC_USE_PG_PIN
  supply1 vpwr, vpb;
  supply0 vgnd, vnb;
`endif

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             tout_q, tout_d;

  logic             sel_vld;
  logic [PTR_W-1:0] sel_id;
  logic [PTR_W-1:0] idx;
  logic             pg_ok;
  logic             rst;

  // Loss of any rail holds the arbiter in reset.
  assign pg_ok = vpwr & vpb & ~vgnd & ~vnb;
  assign rst   = RESET | ~pg_ok;

  // Scan from the pointer downward in priority; the last hit is the nearest to PTR.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = ptr_q;
    idx     = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + PTR_W'(k);
      if (REQ[idx]) begin
        sel_vld = 1'b1;
        sel_id  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN && sel_vld) begin
          state_d = OWN;
          id_d    = sel_id;
          gnt_d   = NREQ'(1) << sel_id;
          cnt_d   = '0;
        end
      end
      OWN: begin
        // A voluntary drop takes precedence over a coincident timeout, so TOUT stays low.
        if (!REQ[id_q] || (TO_EN && cnt_q == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          cnt_d   = '0;
          ptr_d   = id_q + PTR_W'(1);
          tout_d  = REQ[id_q];
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    vld_d = |gnt_d;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = id_q;
  assign GNT_VLD = vld_q;
  assign TOUT    = tout_q;

endmodule
